// File: rtl/divider_ctrl_pkg.sv
// Shared types and helpers for the clock-enable divider controller.
// The optional burst feature is enabled by defining DIVIDER_CTRL_BURST_EN.
package divider_ctrl_pkg;

  localparam int DEFAULT_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  // A divisor of 0 or 1 both mean "enable every cycle".
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d == 32'd0) ? 32'd1 : d;
  endfunction

endpackage

// File: rtl/divider_ctrl_if.sv
// Divide-ratio configuration channel between the control bus and divider_ctrl.
// Handshake: a ratio transfers on a rising edge where cfg_valid && cfg_ready;
// cfg_div is ignored whenever cfg_ready is low, and the master may hold or
// change cfg_valid freely while cfg_ready is low.
interface divider_ctrl_if
  import divider_ctrl_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
);
  logic             cfg_valid;
  logic [CNT_W-1:0] cfg_div;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_div, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_div, output cfg_ready);
endinterface

// File: rtl/divider_ctrl_counter.sv
// Period counter: counts 0..terminal while enabled and strobes on the terminal
// count, wrapping to 0 on that same edge.
module divider_ctrl_counter
  import divider_ctrl_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] terminal,
  output logic             strobe
);

  logic [CNT_W-1:0] count;

  assign strobe = enable && !clear && (count == terminal);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= strobe ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/divider_ctrl.sv
// Clock-enable divider controller: start/stop sequencing, divide-ratio config
// and active-low test-mode override. Optional burst mode: DIVIDER_CTRL_BURST_EN.
module divider_ctrl
  import divider_ctrl_pkg::*;
#(
  parameter int CNT_W       = DEFAULT_CNT_W,
  parameter int DEFAULT_DIV = 1000,
  parameter int TEST_DIV    = 4
) (
  input  logic                 div_clk,
  input  logic                 reset,
  input  logic                 testn,
  input  logic                 start,
  input  logic                 stop,
  divider_ctrl_if.slave        cfg,
  output logic                 ena,
  output logic                 running,
  output state_t               fsm_state
`ifdef DIVIDER_CTRL_BURST_EN
  ,
  input  logic [CNT_W-1:0]     burst_len,
  output logic                 burst_done
`endif
);

  state_t           state, state_n;
  logic [CNT_W-1:0] cur_div, div_reg, pending;
  logic [CNT_W-1:0] sel_div, next_div, terminal;
  logic             pend_v, boundary, load_start, cfg_xfer;
  logic             cnt_clear, cnt_enable, burst_last;

  // A ratio accepted while running waits in pending until the next boundary,
  // so cfg_ready is simply "nothing pending".
  assign cfg.cfg_ready = !pend_v;
  assign cfg_xfer      = cfg.cfg_valid && !pend_v;
  assign running       = (state != ST_IDLE);
  assign fsm_state     = state;

  // The same reload value serves both the IDLE->RUN load and every boundary.
  assign sel_div  = pend_v ? pending : div_reg;
  assign next_div = testn ? CNT_W'(clamp_div(32'(sel_div)))
                          : CNT_W'(clamp_div(32'(TEST_DIV)));
  assign terminal = cur_div - CNT_W'(1);

  assign cnt_clear  = (state == ST_IDLE);
  assign cnt_enable = (state != ST_IDLE);

  divider_ctrl_counter #(.CNT_W(CNT_W)) u_counter (
    .clk      (div_clk),
    .reset    (reset),
    .clear    (cnt_clear),
    .enable   (cnt_enable),
    .terminal (terminal),
    .strobe   (boundary)
  );

`ifdef DIVIDER_CTRL_BURST_EN
  logic [CNT_W-1:0] burst_lim, burst_cnt;

  // A zero length means unlimited; only RUN boundaries end a burst.
  assign burst_last = (state == ST_RUN) && boundary && (burst_lim != '0) &&
                      (burst_cnt == burst_lim - CNT_W'(1));

  always_ff @(posedge div_clk) begin
    if (!reset) begin
      burst_lim  <= '0;
      burst_cnt  <= '0;
      burst_done <= 1'b0;
    end else begin
      burst_done <= burst_last;
      if (load_start) begin
        burst_lim <= burst_len;
        burst_cnt <= '0;
      end else if (boundary) begin
        burst_cnt <= burst_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign burst_last = 1'b0;
`endif

  always_comb begin
    state_n    = state;
    load_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          state_n    = ST_RUN;
          load_start = 1'b1;
        end
      end
      ST_RUN: begin
        if (burst_last)  state_n = ST_IDLE;
        else if (stop)   state_n = ST_STOPPING;
      end
      ST_STOPPING: begin
        if (boundary) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge div_clk) begin
    if (!reset) begin
      state   <= ST_IDLE;
      ena     <= 1'b0;
      cur_div <= CNT_W'(DEFAULT_DIV);
      div_reg <= CNT_W'(DEFAULT_DIV);
      pending <= '0;
      pend_v  <= 1'b0;
    end else begin
      state <= state_n;
      ena   <= boundary;
      if (load_start || boundary) cur_div <= next_div;
      if (boundary && pend_v) begin
        div_reg <= pending;
        pend_v  <= 1'b0;
      end
      if (cfg_xfer) begin
        if (state == ST_IDLE) begin
          div_reg <= cfg.cfg_div;
        end else begin
          pending <= cfg.cfg_div;
          pend_v  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_divider_ctrl.sv
// Randomized scoreboard bench for divider_ctrl: expected ena cycle numbers are
// queued from period arithmetic and popped by a monitor on every ena pulse.
module tb_divider_ctrl;
  import divider_ctrl_pkg::*;

  localparam int W = 16;

  logic   div_clk = 1'b0;
  logic   reset, testn, start, stop;
  logic   ena, running;
  state_t fsm_state;
`ifdef DIVIDER_CTRL_BURST_EN
  logic [W-1:0] burst_len;
  logic         burst_done;
`endif

  divider_ctrl_if #(.CNT_W(W)) cfg_bus ();

  divider_ctrl #(.CNT_W(W), .DEFAULT_DIV(1000), .TEST_DIV(4)) dut (
    .div_clk   (div_clk),
    .reset     (reset),
    .testn     (testn),
    .start     (start),
    .stop      (stop),
    .cfg       (cfg_bus.slave),
    .ena       (ena),
    .running   (running),
    .fsm_state (fsm_state)
`ifdef DIVIDER_CTRL_BURST_EN
    ,
    .burst_len  (burst_len),
    .burst_done (burst_done)
`endif
  );

  // clock / reset
  always #5 div_clk = ~div_clk;

  int cyc = 0;
  always @(posedge div_clk) cyc++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time budget at cycle %0d", cyc);
    $fatal(1);
  end

  // scoreboard
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
  endtask

  always @(negedge div_clk) begin
    if (ena === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_ena: got ena=1, expected none (cycle %0d)", cyc);
      end else begin
        check("ena_time", 32'(cyc), exp_q.pop_front());
      end
    end
  end

  // reference arithmetic
  function automatic int eff_div(input int v, input logic tn);
    if (!tn) return 4;
    return (v <= 1) ? 1 : v;
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge div_clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  task automatic push_pulses(input int first, input int period, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back(32'(first + k * period));
  endtask

  task automatic cfg_idle(input int v);
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = W'(v);
    check("cfg_ready_idle", 32'(cfg_bus.cfg_ready), 32'd1);
    tick();
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic start_run(output int s);
    start = 1'b1;
    tick();
    start = 1'b0;
    s = cyc;
    check("running_after_start", 32'(running), 32'd1);
  endtask

  // Call when cyc equals the last seen pulse; stop lands one cycle later.
  task automatic do_stop(input int last, input int p);
    int fin;
    stop = 1'b1;
    tick();
    stop = 1'b0;
    if (p == 1) begin
      push_pulses(last + 1, 1, 2);
      fin = last + 2;
    end else begin
      push_pulses(last + p, p, 1);
      fin = last + p;
    end
    wait_until(fin);
    check("running_after_stop", 32'(running), 32'd0);
    check("state_after_stop", 32'(fsm_state), 32'(ST_IDLE));
  endtask

  task automatic drain();
    int b = 0;
    tick();
    while (exp_q.size() != 0 && b < 3000) begin
      tick();
      b++;
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (3) tick();
  endtask

  initial begin
    int s, d1, d2, t, p, n, v;
    logic tn;
    reset = 1'b0; testn = 1'b1; start = 1'b0; stop = 1'b0;
    cfg_bus.cfg_valid = 1'b0; cfg_bus.cfg_div = '0;
`ifdef DIVIDER_CTRL_BURST_EN
    burst_len = '0;
`endif

    // reset values and default ratio
    repeat (5) begin
      tick();
      check("reset_ena", 32'(ena), 32'd0);
    end
    check("reset_running", 32'(running), 32'd0);
    check("reset_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("reset_state", 32'(fsm_state), 32'(ST_IDLE));
    reset = 1'b1;
    start_run(s);
    push_pulses(s + 1000, 1000, 3);
    wait_until(s + 3000);
    do_stop(s + 3000, 1000);
    drain();

    // reconfigure while idle, then mid-period
    d1 = $urandom_range(4, 12);
    d2 = $urandom_range(2, 6);
    cfg_idle(d1);
    start_run(s);
    push_pulses(s + d1, d1, 3);
    t = s + 3 * d1;
    wait_until(s + 2 * d1);
    repeat ($urandom_range(1, d1 - 2)) tick();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = W'(d2);
    tick();
    cfg_bus.cfg_div = W'($urandom_range(20, 90));
    check("cfg_ready_drop", 32'(cfg_bus.cfg_ready), 32'd0);
    push_pulses(t + d2, d2, 3);
    wait_until(t - 1);
    check("cfg_ready_held", 32'(cfg_bus.cfg_ready), 32'd0);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    check("cfg_ready_rise", 32'(cfg_bus.cfg_ready), 32'd1);
    wait_until(t + 3 * d2);
    do_stop(t + 3 * d2, d2);
    drain();

    // test-mode override mid-period
    cfg_idle(10);
    start_run(s);
    push_pulses(s + 10, 10, 2);
    wait_until(s + 10);
    repeat ($urandom_range(1, 8)) tick();
    testn = 1'b0;
    tick();
    push_pulses(s + 24, 4, 3);
    wait_until(s + 28);
    repeat ($urandom_range(0, 2)) tick();
    testn = 1'b1;
    tick();
    push_pulses(s + 42, 10, 2);
    wait_until(s + 52);
    do_stop(s + 52, 10);
    drain();

    // start and stop together in IDLE
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    check("start_stop_running", 32'(running), 32'd0);
    check("start_stop_state", 32'(fsm_state), 32'(ST_IDLE));
    repeat (12) begin
      tick();
      check("start_stop_no_ena", 32'(ena), 32'd0);
    end

    // divisors 0 and 1: ena every cycle
    for (int i = 0; i < 2; i++) begin
      cfg_idle(i);
      start_run(s);
      push_pulses(s + 1, 1, 6);
      wait_until(s + 6);
      do_stop(s + 6, 1);
      tick();
      check("edge_div_ena_off", 32'(ena), 32'd0);
      drain();
    end

    // reset mid-period with a pending ratio
    d1 = $urandom_range(8, 20);
    cfg_idle(d1);
    start_run(s);
    push_pulses(s + d1, d1, 1);
    wait_until(s + d1);
    tick();
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_div   = W'(5);
    tick();
    cfg_bus.cfg_valid = 1'b0;
    check("pending_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("midrst_ena", 32'(ena), 32'd0);
    check("midrst_running", 32'(running), 32'd0);
    check("midrst_cfg_ready", 32'(cfg_bus.cfg_ready), 32'd1);
    check("midrst_state", 32'(fsm_state), 32'(ST_IDLE));
    repeat (2) tick();
    reset = 1'b1;
    repeat (2 * d1) begin
      tick();
      check("post_rst_no_ena", 32'(ena), 32'd0);
    end
    check("post_rst_queue", 32'(exp_q.size()), 32'd0);

    // randomized runs
    for (int it = 0; it < 8; it++) begin
      v  = $urandom_range(0, 12);
      tn = ($urandom_range(0, 3) != 0);
      cfg_idle(v);
      testn = tn;
      start_run(s);
      p = eff_div(v, tn);
      n = $urandom_range(1, 4);
      push_pulses(s + p, p, n);
      wait_until(s + n * p);
      do_stop(s + n * p, p);
      testn = 1'b1;
      drain();
    end

`ifdef DIVIDER_CTRL_BURST_EN
    // burst of three pulses, period five
    cfg_idle(5);
    burst_len = W'(3);
    start_run(s);
    push_pulses(s + 5, 5, 3);
    wait_until(s + 14);
    check("burst_done_early", 32'(burst_done), 32'd0);
    tick();
    check("burst_done_pulse", 32'(burst_done), 32'd1);
    tick();
    check("burst_done_clear", 32'(burst_done), 32'd0);
    check("burst_running", 32'(running), 32'd0);
    burst_len = '0;
    drain();
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/divider_ctrl.md
Name: divider_ctrl

Overview:
- Control block that sequences and configures the clock-enable divider.
- Owns the divide ratio, start/stop sequencing and active-low test-mode override.
- Produces a single-cycle `ena` pulse train for downstream logic.
- Sits between the system control/config bus and every consumer of `ena`.

Parameters:
- CNT_W, 16, width of the divide ratio and period counter.
- DEFAULT_DIV, 1000, divide ratio loaded at reset.
- TEST_DIV, 4, divide ratio forced while `testn`=0.

Ports:
- div_clk, in, 1, sole clock; all logic updates on its rising edge.
- reset, in, 1, synchronous active-low reset, sampled at the rising edge of `div_clk`.
- testn, in, 1, active-low test mode; 0 selects TEST_DIV.
- start, in, 1, single-cycle request to begin pulse generation.
- stop, in, 1, single-cycle request to end pulse generation.
- cfg_valid, in, 1, new divide ratio offered.
- cfg_div, in, CNT_W, offered divide ratio.
- cfg_ready, out, 1, ratio can be accepted this cycle.
- ena, out, 1, registered enable pulse, one cycle wide.
- running, out, 1, high in RUN and STOPPING.

Behaviour:
- Clocking and reset:
  - One clock (`div_clk`); reset is synchronous and active-low (`reset`).
  - reset=0 at a clock edge sets: state=IDLE, counter=0, div_reg=DEFAULT_DIV, cur_div=DEFAULT_DIV, pending=0, ena=0, running=0, cfg_ready=1.
  - Reset mid-period aborts immediately; no final `ena` pulse.
- Divisor value:
  - Effective divisor d is cfg value, or TEST_DIV when `testn`=0.
  - d of 0 or 1 is treated as 1, so `ena` stays high every cycle while RUN.
- Counter:
  - Counts 0..cur_div-1.
  - At counter==cur_div-1 (the boundary), the counter wraps to 0 and `ena` is registered high for the next cycle.
  - Otherwise `ena`=0.
- State IDLE:
  - Counter held at 0, ena=0, running=0.
  - start=1 → RUN; counter starts at 0 next cycle.
  - cur_div is loaded at the transition: TEST_DIV if testn=0, else div_reg.
  - First `ena` is high exactly cur_div cycles after the start-sampling edge.
  - start and stop both high in the same cycle: stop wins, state stays IDLE.
- State RUN:
  - stop=1 → STOPPING.
  - start is ignored.
- State STOPPING:
  - Completes the current period and emits its final `ena`.
  - Enters IDLE on the same edge that registers that pulse.
  - start is ignored; a repeated stop is ignored.
- Boundary reload:
  - At each boundary, cur_div reloads from testn/div_reg.
  - A `testn` change mid-period takes effect at the next boundary only.
- Config handshake:
  - Transfer occurs when cfg_valid && cfg_ready.
  - In IDLE: cfg_ready=1; div_reg updates on the next edge.
  - In RUN/STOPPING:
    - The accepted value is stored in `pending`, and cfg_ready drops the next cycle.
    - At the next boundary, div_reg takes the pending value and is used for that same reload; pending is cleared.
    - cfg_ready returns to 1 the following cycle.
  - cfg_div is not sampled when cfg_ready=0.
- Counter width: CNT_W bits unsigned, no overflow possible because counter < cur_div ≤ 2^CNT_W−1.

Optional Feature:
- Macro: DIVIDER_CTRL_BURST_EN.
- When defined:
  - Adds input `burst_len[CNT_W]` and output `burst_done` (1 cycle).
  - burst_len is latched on the IDLE→RUN transition.
  - After burst_len `ena` pulses, the controller returns to IDLE exactly as in STOPPING, and burst_done pulses coincident with the last `ena`.
  - burst_len=0 means unlimited.
  - Manual stop still works; burst_done is not asserted on a manual stop.
- When undefined: ports absent; the controller runs until stop.

Decomposition:
- Package divider_ctrl_pkg holds:
  - State enum (IDLE, RUN, STOPPING).
  - Default CNT_W.
  - Helper function clamping a divisor to ≥1.
- Sub-module divider_ctrl_counter:
  - Loadable period counter, CNT_W wide.
  - Inputs: clear, enable, terminal value.
  - Output: one-cycle terminal strobe.
- FSM, config handshake and test-mode override stay in the top module.

Test Plan:
- Reset and default ratio: hold reset=0 for 5 cycles, then set it to 1, testn=1, pulse start. Expected: ena=0 throughout reset; first ena exactly 1000 cycles after start; pulses repeat every 1000 cycles.
- Reconfigure while idle: in IDLE, send cfg_div=7, then start. Expected: ena every 7 cycles. Then send cfg_div=3 mid-period. Expected: cfg_ready drops; the current 7-cycle period completes; subsequent periods are 3 cycles; cfg_ready rises one cycle after the boundary.
- Test-mode override: running with d=10, drive testn=0 mid-period. Expected: the current period stays 10; following periods are 4. Return testn=1. Expected: period 10 after the next boundary.
- Stop and start interaction:
  - stop during RUN: exactly one more ena at the end of the current period, then running=0.
  - start and stop together in IDLE: no ena, state stays IDLE.
- Reset mid-operation and edge divisors:
  - reset=0 mid-period: ena never asserts after that edge; all outputs at reset values.
  - cfg_div=0 and cfg_div=1: ena constantly high while RUN.
- Burst mode (with DIVIDER_CTRL_BURST_EN): burst_len=3, d=5. Expected: exactly 3 ena pulses 5 cycles apart; burst_done coincides with the third; running=0 the next cycle.
